// File: rtl/xintf_master_ctrl.sv
// XINTF bus master: one register-driven CE/WE/RD/XA/XD cycle per accepted request.
// Latency: request to o_done = LEAD_CYC+ACTIVE_CYC+TRAIL_CYC+1 cycles.
// Backpressure: i_req is only sampled in IDLE; requests while busy are dropped.
module xintf_master_ctrl #(
  parameter int LEAD_CYC   = 2,
  parameter int ACTIVE_CYC = 3,
  parameter int TRAIL_CYC  = 1
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_req,
  input  logic        i_wr,
  input  logic [8:0]  i_addr,
  input  logic [15:0] i_wdata,
  output logic        o_busy,
  output logic        o_done,
  output logic [15:0] o_rdata,
  output logic        o_dsp_ce,
  output logic        o_dsp_we,
  output logic        o_dsp_rd,
  output logic [8:0]  o_dsp_xa,
  inout  wire  [15:0] io_dsp_xd,
  output logic [15:0] o_xfer_cnt
);

  localparam logic [3:0] LEAD_LD   = 4'(LEAD_CYC - 1);
  localparam logic [3:0] ACTIVE_LD = 4'(ACTIVE_CYC - 1);
  localparam logic [3:0] TRAIL_LD  = 4'(TRAIL_CYC - 1);

  typedef enum logic [1:0] {IDLE, LEAD, ACTIVE, TRAIL} state_t;

  state_t      state_q, state_nxt;
  logic [3:0]  phase_q, phase_nxt;
  logic        accept, capture, done_nxt;
  logic        wr_q, wr_nxt;
  logic [8:0]  addr_q, addr_nxt;
  logic [15:0] wdata_q;
  logic        xd_oe_q;

  always_comb begin
    state_nxt = state_q;
    phase_nxt = phase_q;
    accept    = 1'b0;
    capture   = 1'b0;
    done_nxt  = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_req) begin
          accept    = 1'b1;
          state_nxt = LEAD;
          phase_nxt = LEAD_LD;
        end
      end
      LEAD: begin
        if (phase_q == 4'd0) begin
          state_nxt = ACTIVE;
          phase_nxt = ACTIVE_LD;
        end else begin
          phase_nxt = phase_q - 4'd1;
        end
      end
      ACTIVE: begin
        if (phase_q == 4'd0) begin
          state_nxt = TRAIL;
          phase_nxt = TRAIL_LD;
          capture   = ~wr_q;
        end else begin
          phase_nxt = phase_q - 4'd1;
        end
      end
      TRAIL: begin
        if (phase_q == 4'd0) begin
          state_nxt = IDLE;
          phase_nxt = 4'd0;
          done_nxt  = 1'b1;
        end else begin
          phase_nxt = phase_q - 4'd1;
        end
      end
      default: begin
        state_nxt = IDLE;
        phase_nxt = 4'd0;
      end
    endcase
    wr_nxt   = accept ? i_wr   : wr_q;
    addr_nxt = accept ? i_addr : addr_q;
  end

  // Bus pins are registered from the next-state view so they change on the
  // same edge as the state, keeping CE low time equal to the phase total.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q    <= IDLE;
      phase_q    <= 4'd0;
      wr_q       <= 1'b0;
      addr_q     <= 9'd0;
      wdata_q    <= 16'd0;
      xd_oe_q    <= 1'b0;
      o_dsp_ce   <= 1'b1;
      o_dsp_we   <= 1'b1;
      o_dsp_rd   <= 1'b1;
      o_dsp_xa   <= 9'd0;
      o_busy     <= 1'b0;
      o_done     <= 1'b0;
      o_rdata    <= 16'd0;
      o_xfer_cnt <= 16'd0;
    end else begin
      state_q  <= state_nxt;
      phase_q  <= phase_nxt;
      wr_q     <= wr_nxt;
      addr_q   <= addr_nxt;
      if (accept) begin
        wdata_q <= i_wdata;
      end
      xd_oe_q  <= (state_nxt != IDLE) && wr_nxt;
      o_dsp_ce <= (state_nxt == IDLE);
      o_dsp_we <= ~((state_nxt == ACTIVE) && wr_nxt);
      o_dsp_rd <= ~((state_nxt == ACTIVE) && !wr_nxt);
      o_dsp_xa <= (state_nxt == IDLE) ? 9'd0 : addr_nxt;
      o_busy   <= (state_nxt != IDLE);
      o_done   <= done_nxt;
      if (done_nxt) begin
        o_xfer_cnt <= o_xfer_cnt + 16'd1;
      end
      if (capture) begin
        o_rdata <= io_dsp_xd;
      end
    end
  end

  assign io_dsp_xd = xd_oe_q ? wdata_q : 16'bz;

endmodule

// File: tb/tb_xintf_master_ctrl.sv
// Scoreboard bench for xintf_master_ctrl: cycle-accurate bus model plus completion queue.
module tb_xintf_master_ctrl;
  localparam int L = 2, A = 3, T = 1, TOT = L + A + T;

  logic        clk = 1'b0;
  logic        rst_n, req, wr;
  logic [8:0]  addr;
  logic [15:0] wdata, resp_val;
  logic        busy, done, ce, we, rd;
  logic [15:0] rdata, xfer_cnt;
  logic [8:0]  xa;
  wire  [15:0] xd;

  always #5 clk = ~clk;

  // External device: drives the data bus only while the read strobe is low.
  assign xd = (rd == 1'b0) ? resp_val : 16'bz;

  xintf_master_ctrl #(.LEAD_CYC(L), .ACTIVE_CYC(A), .TRAIL_CYC(T)) dut (
    .i_clk(clk), .i_rst(rst_n), .i_req(req), .i_wr(wr), .i_addr(addr), .i_wdata(wdata),
    .o_busy(busy), .o_done(done), .o_rdata(rdata), .o_dsp_ce(ce), .o_dsp_we(we),
    .o_dsp_rd(rd), .o_dsp_xa(xa), .io_dsp_xd(xd), .o_xfer_cnt(xfer_cnt)
  );

  typedef struct {int c; logic wr; logic [8:0] addr; logic [15:0] wdata;} bus_t;
  typedef struct {logic [15:0] rdata; logic [15:0] cnt;} done_t;

  bus_t        bus_q[$];
  done_t       done_q[$];
  int          cyc = 0;
  int          free_at = 0;
  logic [15:0] cnt_m = 16'd0, rdata_m = 16'd0;
  int          compared = 0, mismatched = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference model: a request seen at edge e is taken iff the master is free by then;
  // it then owns the bus for TOT cycles and the next edge after the done cycle is free.
  task automatic apply(input logic rq, input logic w, input logic [8:0] ad,
                       input logic [15:0] wd, input logic [15:0] rv);
    bus_t  b;
    done_t d;
    req = rq; wr = w; addr = ad; wdata = wd;
    if (rq && rst_n && (cyc + 1) >= free_at) begin
      b.c = cyc + 1; b.wr = w; b.addr = ad; b.wdata = wd;
      bus_q.push_back(b);
      free_at = cyc + 1 + TOT + 1;
      cnt_m = cnt_m + 16'd1;
      if (!w) rdata_m = rv;
      d.rdata = rdata_m; d.cnt = cnt_m;
      done_q.push_back(d);
      resp_val = rv;
    end
  endtask

  task automatic drive(input logic rq, input logic w, input logic [8:0] ad,
                       input logic [15:0] wd, input logic [15:0] rv);
    @(posedge clk); #1;
    apply(rq, w, ad, wd, rv);
  endtask

  task automatic drive_rand(input logic rq);
    drive(rq, 1'($urandom), 9'($urandom), 16'($urandom), 16'($urandom));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive_rand(1'b0);
  endtask

  // Monitor: per-cycle bus/status check against the model window, plus completion scoreboard.
  always @(negedge clk) begin
    int          n, k;
    logic        act, inwin, wwin;
    logic [13:0] ev, av;
    bus_t        f;
    done_t       d;
    n = cyc;
    while (bus_q.size() > 0 && n > bus_q[0].c + TOT) void'(bus_q.pop_front());
    ev = {1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 9'h000};
    inwin = 1'b0;
    wwin  = 1'b0;
    if (bus_q.size() > 0) begin
      f = bus_q[0];
      if (n >= f.c && n < f.c + TOT) begin
        k = n - f.c + 1;
        act = (k > L) && (k <= L + A);
        ev = {1'b0, !(act && f.wr), !(act && !f.wr), 1'b1, 1'b0, f.addr};
        inwin = 1'b1;
        wwin  = f.wr;
      end else if (n == f.c + TOT) begin
        ev[9] = 1'b1;
      end
    end
    av = {ce, we, rd, busy, done, xa};
    chk("bus_ce_we_rd_busy_done_xa", 32'(av), 32'(ev));
    if (inwin && wwin) begin
      chk("xd_write_data", 32'(xd), 32'(f.wdata));
    end else if (rd) begin
      chk("xd_released", 32'((xd === 16'bz) || (xd == 16'h0000)), 32'd1);
    end
    if (done) begin
      if (done_q.size() == 0) begin
        chk("done_unexpected", 32'd1, 32'd0);
      end else begin
        d = done_q.pop_front();
        chk("rdata_at_done", 32'(rdata), 32'(d.rdata));
        chk("xfer_cnt_at_done", 32'(xfer_cnt), 32'(d.cnt));
      end
    end
  end

  initial begin
    #200000;
    mismatched++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; req = 1'b0; wr = 1'b0; addr = 9'd0; wdata = 16'd0; resp_val = 16'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_rdata", 32'(rdata), 32'd0);
    chk("reset_xfer_cnt", 32'(xfer_cnt), 32'd0);
    chk("reset_pins", 32'({ce, we, rd, busy, done, xa}), 32'({3'b111, 2'b00, 9'h000}));

    // Release with a write pending: it must be taken on the first edge.
    rst_n = 1'b1;
    apply(1'b1, 1'b1, 9'h055, 16'hA5C3, 16'h0000);
    idle(TOT + 1);

    drive(1'b1, 1'b0, 9'h1FF, 16'h5A5A, 16'h1234);
    idle(TOT + 1);

    // Request held high across three back-to-back transactions.
    for (int i = 0; i < 3 * (TOT + 1); i++) drive_rand(1'b1);
    idle(TOT + 1);

    // Request pulsed mid-transaction must be dropped.
    drive(1'b1, 1'b1, 9'h0AA, 16'hBEEF, 16'h0);
    idle(L);
    drive_rand(1'b1);
    idle(TOT + 2);

    // Reset asserted during ACTIVE of a write aborts it silently.
    drive(1'b1, 1'b1, 9'h123, 16'hCAFE, 16'h0);
    idle(L + 1);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("abort_pins", 32'({ce, we, rd, busy, done}), 32'({3'b111, 2'b00}));
    chk("abort_xd_released", 32'((xd === 16'bz) || (xd == 16'h0000)), 32'd1);
    chk("abort_xfer_cnt", 32'(xfer_cnt), 32'd0);
    bus_q.delete();
    done_q.delete();
    cnt_m = 16'd0; rdata_m = 16'd0; free_at = 0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(3);

    // Counter wrap from a preloaded value.
    @(posedge clk); #1;
    force dut.o_xfer_cnt = 16'hFFFE;
    #1;
    release dut.o_xfer_cnt;
    cnt_m = 16'hFFFE;
    drive(1'b1, 1'b0, 9'h001, 16'h0, 16'h7E57);
    idle(TOT + 1);
    drive(1'b1, 1'b1, 9'h002, 16'h0F0F, 16'h0);
    idle(TOT + 1);
    chk("wrap_xfer_cnt", 32'(xfer_cnt), 32'd0);

    for (int i = 0; i < 400; i++) drive_rand(($urandom_range(0, 2) != 0) ? 1'b1 : 1'b0);
    idle(TOT + 3);
    chk("scoreboard_drained", 32'(done_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/xintf_master_ctrl.md
XINTF_MASTER_CTRL -- requirements
Module: xintf_master_ctrl

Interface
REQ-001 SHALL have parameter LEAD_CYC, default 2, meaning cycles from CE low to strobe low (legal range 1..15).
REQ-002 SHALL have parameter ACTIVE_CYC, default 3, meaning cycles the WE/RD strobe is held low (legal range 1..15).
REQ-003 SHALL have parameter TRAIL_CYC, default 1, meaning cycles from strobe high to CE high (legal range 1..15).
REQ-004 SHALL have the port i_clk, input, 1 bit, the single system clock; all logic runs on its rising edge.
REQ-005 SHALL have the port i_rst, input, 1 bit, reset that is asynchronous and active-low.
REQ-006 SHALL have the port i_req, input, 1 bit, transaction request, sampled only in IDLE.
REQ-007 SHALL have the port i_wr, input, 1 bit, transaction type: 1 = write, 0 = read.
REQ-008 SHALL have the port i_addr, input, 9 bits, target XINTF address.
REQ-009 SHALL have the port i_wdata, input, 16 bits, write data.
REQ-010 SHALL have the port o_busy, output, 1 bit, high while a transaction is in progress.
REQ-011 SHALL have the port o_done, output, 1 bit, one-cycle completion pulse.
REQ-012 SHALL have the port o_rdata, output, 16 bits, last captured read data.
REQ-013 SHALL have the port o_dsp_ce, output, 1 bit, chip enable, active-low.
REQ-014 SHALL have the port o_dsp_we, output, 1 bit, write strobe, active-low.
REQ-015 SHALL have the port o_dsp_rd, output, 1 bit, read strobe, active-low.
REQ-016 SHALL have the port o_dsp_xa, output, 9 bits, bus address.
REQ-017 SHALL have the port io_dsp_xd, inout, 16 bits, bidirectional data bus.
REQ-018 SHALL have the port o_xfer_cnt, output, 16 bits, count of completed transactions.

Function
REQ-019 SHALL implement the FSM states IDLE, LEAD, ACTIVE, TRAIL, with one shared 4-bit phase counter.
REQ-020 SHALL, in IDLE with i_req=1 at a rising edge, latch i_wr/i_addr/i_wdata and enter LEAD.
REQ-021 SHALL ignore i_req while not in IDLE, with no queuing.
REQ-022 SHALL, in LEAD, drive o_dsp_ce=0, o_dsp_we=1, o_dsp_rd=1 and o_dsp_xa=latched address for exactly LEAD_CYC cycles, then enter ACTIVE.
REQ-023 SHALL, in ACTIVE, keep o_dsp_ce=0 and drive o_dsp_we=0 (write) or o_dsp_rd=0 (read) for exactly ACTIVE_CYC cycles, then enter TRAIL.
REQ-024 SHALL, in TRAIL, drive both strobes high and keep o_dsp_ce=0 and o_dsp_xa held for exactly TRAIL_CYC cycles, then return to IDLE.
REQ-025 SHALL drive io_dsp_xd with the latched write data during LEAD, ACTIVE and TRAIL of a write only; io_dsp_xd SHALL be high-Z at all other times.
REQ-026 SHALL, on a read, capture io_dsp_xd into o_rdata at the rising edge that ends the last ACTIVE cycle, and SHALL leave o_rdata unchanged on writes.
REQ-027 SHALL drive o_dsp_ce, o_dsp_we, o_dsp_rd and o_dsp_xa from registers, with no combinational path from any input.
REQ-028 SHALL drive o_dsp_xa to 0 in IDLE.
REQ-029 SHALL hold o_busy=1 in LEAD, ACTIVE and TRAIL, and o_busy=0 in IDLE.
REQ-030 SHALL pulse o_done=1 for exactly one cycle, in the first IDLE cycle after TRAIL, coincident with o_dsp_ce returning to 1.
REQ-031 SHALL increment o_xfer_cnt by 1 on each o_done, wrapping 16'hFFFF to 0.
REQ-032 SHALL accept an i_req asserted during the o_done cycle, so that back-to-back transactions give exactly 1 cycle of o_dsp_ce=1 between transactions; the strobes SHALL never be low while o_dsp_ce=1.
REQ-033 SHALL make a transaction's o_dsp_ce low time exactly LEAD_CYC+ACTIVE_CYC+TRAIL_CYC cycles, and its request-to-o_done latency exactly LEAD_CYC+ACTIVE_CYC+TRAIL_CYC+1 cycles.
REQ-034 SHALL never assert o_dsp_we and o_dsp_rd low together.

Reset
REQ-035 SHALL, with i_rst=0, immediately and asynchronously force the state to IDLE, o_dsp_ce=1, o_dsp_we=1, o_dsp_rd=1, o_dsp_xa=0, io_dsp_xd=high-Z, o_busy=0, o_done=0, o_rdata=0 and o_xfer_cnt=0.
REQ-036 SHALL, when reset is asserted mid-transaction, abort that transaction with no o_done and no o_xfer_cnt increment.
REQ-037 SHALL, after reset release, accept a new i_req on the first rising edge.

Verification
REQ-038 SHALL cover a write: defaults, i_wr=1, i_addr=9'h055, i_wdata=16'hA5C3 -> CE low 6 cycles, WE low cycles 3-5, XD=A5C3 throughout, o_done at cycle 7, o_xfer_cnt=1.
REQ-039 SHALL cover a read: i_wr=0, i_addr=9'h1FF, bench drives XD=16'h1234 during ACTIVE -> RD low 3 cycles, XD high-Z from FPGA, o_rdata=1234 at o_done.
REQ-040 SHALL cover back-to-back: i_req held high for 3 transactions -> exactly 1 CE-high cycle between each, o_xfer_cnt=3.
REQ-041 SHALL cover a busy request: i_req pulsed during ACTIVE -> no additional transaction, o_xfer_cnt unchanged by it.
REQ-042 SHALL cover reset mid-op: i_rst=0 during ACTIVE of a write -> CE/WE high and XD high-Z within the same cycle, no o_done, o_xfer_cnt=0.
REQ-043 SHALL cover counter wrap: o_xfer_cnt preloaded via 65535 transactions (or force) plus 1 more -> o_xfer_cnt=0.
